// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared constants and types for the DMEM port arbiter.
//               Owner encoding for read responses, the address bit that
//               selects memory-mapped I/O, and default bus widths.
// Revision    : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;
  localparam int STARVE_W       = 4;
  localparam int MMIO_SEL_BIT   = 31;

  // Which requester a pending read response belongs to.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_if
// Description : Bundle of every bus signal around the DMEM arbiter.
//               CPU side   : cpu_req/we/addr/wdata in, cpu_gnt/rvalid/rdata out
//               Loader side: ldr_req/we/addr/wdata in, ldr_gnt/rvalid/rdata,
//                            ldr_err out
//               DMEM side  : mem_we/ask_addr/fetch_addr/wdata out, mem_rdata in
//               slave  modport is taken by the arbiter, master by whatever
//               drives requesters and models the memory.
// Revision    : 1.0  initial release
// ============================================================================
interface dmem_arb_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_err;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_ask_addr;
  logic [ADDR_W-1:0] mem_fetch_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata, ldr_err,
    output mem_we, mem_ask_addr, mem_fetch_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata, ldr_err,
    input  mem_we, mem_ask_addr, mem_fetch_addr, mem_wdata
  );

endinterface : dmem_arb_if
`default_nettype wire

// File: rtl/dmem_arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_starve_cnt
// Description : Counts consecutive CPU grants taken while the loader waits.
//               Saturates at STARVE_MAX; at_limit tells the arbiter to hand
//               the next cycle to the loader.
//   clk, rst   : clock, synchronous active-high reset
//   cpu_gnt    : CPU granted this cycle
//   ldr_req    : loader requesting this cycle
//   ldr_gnt    : loader granted this cycle
//   starve_cnt : current count
//   at_limit   : starve_cnt == STARVE_MAX
// Revision    : 1.0  initial release
// ============================================================================
module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                cpu_gnt,
  input  wire logic                ldr_req,
  input  wire logic                ldr_gnt,
  output logic      [STARVE_W-1:0] starve_cnt,
  output logic                     at_limit
);

  localparam logic [STARVE_W-1:0] c_starve_max = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] r_cnt;

  // Clearing wins over counting: once the loader is served (or gives up)
  // the CPU gets a fresh run of STARVE_MAX grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (ldr_gnt || !ldr_req) begin
      r_cnt <= '0;
    end else if (cpu_gnt && (r_cnt != c_starve_max)) begin
      r_cnt <= r_cnt + STARVE_W'(1);
    end
  end

  assign starve_cnt = r_cnt;
  assign at_limit   = (r_cnt == c_starve_max);

endmodule : dmem_arb_starve_cnt
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single DMEM port between the CPU MEM stage and a
//               debug/program loader. Fixed CPU priority, bounded by a
//               starvation counter. Ask address/wdata/we go out in the grant
//               cycle; the fetch address is the previous cycle's granted
//               address so DMEM's MMIO-vs-BRAM select lines up with the
//               1-cycle BRAM read. Read data returns to the granted requester
//               exactly one cycle after the grant.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dmem_arb_if.slave (CPU, loader and DMEM signals)
// Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  wire logic clk,
  input  wire logic rst,
  dmem_arb_if.slave bus
);

  localparam logic [STARVE_W-1:0] c_starve_max = STARVE_W'(STARVE_MAX);

  logic                w_cpu_gnt;
  logic                w_ldr_gnt;
  logic                w_at_limit;
  logic [STARVE_W-1:0] w_starve_cnt;
  logic                w_ldr_mmio_wr;
  logic [ADDR_W-1:0]   w_ask_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_we;
  logic                w_cpu_rvalid;
  logic                w_ldr_rvalid;

  logic                r_resp_pending;
  owner_e              r_resp_owner;
  logic [ADDR_W-1:0]   r_fetch_addr;
  logic                r_ldr_err;

  // --------------------------------------------------------------------------
  // Starvation counter
  // --------------------------------------------------------------------------
  dmem_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk        (clk),
    .rst        (rst),
    .cpu_gnt    (w_cpu_gnt),
    .ldr_req    (bus.ldr_req),
    .ldr_gnt    (w_ldr_gnt),
    .starve_cnt (w_starve_cnt),
    .at_limit   (w_at_limit)
  );

  // --------------------------------------------------------------------------
  // Grant and memory drive
  // --------------------------------------------------------------------------
  always_comb begin
    w_ldr_gnt     = 1'b0;
    w_cpu_gnt     = 1'b0;
    w_ldr_mmio_wr = bus.ldr_we & bus.ldr_addr[MMIO_SEL_BIT];
    w_ask_addr    = '0;
    w_wdata       = '0;
    w_we          = 1'b0;

    if (!rst) begin
      w_ldr_gnt = bus.ldr_req & (~bus.cpu_req | w_at_limit);
      w_cpu_gnt = bus.cpu_req & ~w_ldr_gnt;
    end

    if (w_cpu_gnt) begin
      w_ask_addr = bus.cpu_addr;
      w_wdata    = bus.cpu_wdata;
      w_we       = bus.cpu_we;
    end else if (w_ldr_gnt) begin
      w_ask_addr = bus.ldr_addr;
      w_wdata    = bus.ldr_wdata;
      // The loader may read operand registers but never write MMIO.
      w_we       = bus.ldr_we & ~w_ldr_mmio_wr;
    end
  end

  // --------------------------------------------------------------------------
  // Response tracking, fetch address and loader error
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_pending <= 1'b0;
      r_resp_owner   <= OWN_CPU;
      r_fetch_addr   <= '0;
      r_ldr_err      <= 1'b0;
    end else begin
      r_resp_pending <= (w_cpu_gnt & ~bus.cpu_we) | (w_ldr_gnt & ~bus.ldr_we);
      r_resp_owner   <= w_ldr_gnt ? OWN_LDR : OWN_CPU;
      r_fetch_addr   <= w_ask_addr;
      r_ldr_err      <= w_ldr_gnt & w_ldr_mmio_wr;
    end
  end

  // Gating with rst kills a response whose grant came the cycle before
  // reset asserted; the registers themselves only clear on the next edge.
  assign w_cpu_rvalid = r_resp_pending & ~rst & (r_resp_owner == OWN_CPU);
  assign w_ldr_rvalid = r_resp_pending & ~rst & (r_resp_owner == OWN_LDR);

  assign bus.cpu_gnt        = w_cpu_gnt;
  assign bus.ldr_gnt        = w_ldr_gnt;
  assign bus.mem_we         = w_we;
  assign bus.mem_ask_addr   = w_ask_addr;
  assign bus.mem_wdata      = w_wdata;
  assign bus.mem_fetch_addr = r_fetch_addr;
  assign bus.cpu_rvalid     = w_cpu_rvalid;
  assign bus.cpu_rdata      = w_cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.ldr_rvalid     = w_ldr_rvalid;
  assign bus.ldr_rdata      = w_ldr_rvalid ? bus.mem_rdata : '0;
  assign bus.ldr_err        = r_ldr_err & ~rst;

  a_starve_bound : assert property (@(posedge clk) disable iff (rst)
    w_starve_cnt <= c_starve_max);

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. Models DMEM (BRAM with
//               one-cycle read on ask_addr, MMIO operand registers muxed on
//               fetch_addr) and checks every output each cycle against a
//               cycle-level reference of the arbitration rules. Directed
//               vector table, starvation and reset sequences, then random
//               traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic init_mem;
  always #5 clk = ~clk;

  dmem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------------------------------------------------------- DMEM model
  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'hB000_0000 | 32'(i));
  endfunction

  function automatic logic [31:0] init_mmio(input int i);
    case (i)
      0:       return 32'h0000_005A;
      1:       return 32'h0000_0011;
      2:       return 32'h0000_0099;
      default: return 32'h0000_0033;
    endcase
  endfunction

  logic [31:0] bram [0:255];
  logic [31:0] mmio [0:3];
  logic [31:0] bram_q;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) bram[i] <= init_word(i);
      for (int i = 0; i < 4; i++) mmio[i] <= init_mmio(i);
    end else if (bus.mem_we) begin
      if (bus.mem_ask_addr[31]) mmio[bus.mem_ask_addr[3:2]] <= bus.mem_wdata;
      else                      bram[bus.mem_ask_addr[9:2]] <= bus.mem_wdata;
    end
    bram_q <= bram[bus.mem_ask_addr[9:2]];
  end

  assign bus.mem_rdata = bus.mem_fetch_addr[31] ? mmio[bus.mem_fetch_addr[3:2]] : bram_q;

  // ---------------------------------------------------------------- checking
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------- reference
  logic [31:0] ref_bram [0:255];
  logic [31:0] ref_mmio [0:3];
  int          m_wait;      // CPU grants taken in a row while the loader waited
  bit          m_pend;
  bit          m_own_ldr;
  logic [31:0] m_data;
  logic [31:0] m_fetch;
  bit          m_err;
  // per-cycle expectations, computed at negedge and consumed at posedge
  bit          e_cg, e_lg, e_we;
  logic [31:0] e_addr, e_wd;

  task automatic model_reset();
    m_wait = 0; m_pend = 0; m_own_ldr = 0; m_data = '0; m_fetch = '0; m_err = 0;
  endtask

  task automatic model_check();
    bit crv, lrv;
    e_lg   = !rst && bus.ldr_req && (!bus.cpu_req || m_wait >= SMAX);
    e_cg   = !rst && bus.cpu_req && !e_lg;
    e_addr = e_cg ? bus.cpu_addr  : (e_lg ? bus.ldr_addr  : 32'h0);
    e_wd   = e_cg ? bus.cpu_wdata : (e_lg ? bus.ldr_wdata : 32'h0);
    e_we   = e_cg ? bus.cpu_we : (e_lg ? (bus.ldr_we && !bus.ldr_addr[31]) : 1'b0);
    crv    = !rst && m_pend && !m_own_ldr;
    lrv    = !rst && m_pend && m_own_ldr;
    chk("cpu_gnt",    bus.cpu_gnt, e_cg);
    chk("ldr_gnt",    bus.ldr_gnt, e_lg);
    chk("one_grant",  bus.cpu_gnt & bus.ldr_gnt, 0);
    chk("mem_we",     bus.mem_we, e_we);
    chk("ask_addr",   bus.mem_ask_addr, e_addr);
    chk("mem_wdata",  bus.mem_wdata, e_wd);
    chk("fetch_addr", bus.mem_fetch_addr, rst ? bus.mem_fetch_addr : m_fetch);
    chk("cpu_rvalid", bus.cpu_rvalid, crv);
    chk("cpu_rdata",  bus.cpu_rdata, crv ? m_data : 32'h0);
    chk("ldr_rvalid", bus.ldr_rvalid, lrv);
    chk("ldr_rdata",  bus.ldr_rdata, lrv ? m_data : 32'h0);
    chk("ldr_err",    bus.ldr_err, !rst && m_err);
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
    end else begin
      m_fetch   = e_addr;
      m_pend    = (e_cg && !bus.cpu_we) || (e_lg && !bus.ldr_we);
      m_own_ldr = e_lg;
      m_data    = e_addr[31] ? ref_mmio[e_addr[3:2]] : ref_bram[e_addr[9:2]];
      m_err     = e_lg && bus.ldr_we && bus.ldr_addr[31];
      if (e_we) begin
        if (e_addr[31]) ref_mmio[e_addr[3:2]] = e_wd;
        else            ref_bram[e_addr[9:2]] = e_wd;
      end
      if (!bus.ldr_req || e_lg) m_wait = 0;
      else if (e_cg)            m_wait = (m_wait + 1 > SMAX) ? SMAX : m_wait + 1;
    end
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    finish_cycle();
  endtask

  task automatic set_cpu(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_req = r; bus.cpu_we = w; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_ldr(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    bus.ldr_req = r; bus.ldr_we = w; bus.ldr_addr = a; bus.ldr_wdata = d;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        cr, cw;  logic [31:0] ca, cd;
    logic        lr, lw;  logic [31:0] la, ld;
    logic        gc, gl, we;
    logic [31:0] fa;
    logic        crv;     logic [31:0] crd;
    logic        lrv;     logic [31:0] lrd;
    logic        err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    bit ldr_hold;

    // CPU read 0x10 -> DEADBEEF one cycle later
    tbl[0] = '{1, 0, 32'h10, 0,  0, 0, 0, 0,                   1, 0, 0, 32'h0,        0, 0,            0, 0,     0};
    tbl[1] = '{0, 0, 0, 0,       0, 0, 0, 0,                   0, 0, 0, 32'h10,       1, 32'hDEADBEEF, 0, 0,     0};
    // loader MMIO write is dropped and flagged
    tbl[2] = '{0, 0, 0, 0,       1, 1, 32'h8000_0008, 32'h1234, 0, 1, 0, 32'h0,       0, 0,            0, 0,     0};
    tbl[3] = '{0, 0, 0, 0,       0, 0, 0, 0,                   0, 0, 0, 32'h8000_0008, 0, 0,           0, 0,     1};
    // CPU read then loader MMIO read on consecutive cycles
    tbl[4] = '{1, 0, 32'h4, 0,   0, 0, 0, 0,                   1, 0, 0, 32'h0,        0, 0,            0, 0,     0};
    tbl[5] = '{0, 0, 0, 0,       1, 0, 32'h8000_0000, 0,       0, 1, 0, 32'h4,        1, 32'hB0000001, 0, 0,     0};
    tbl[6] = '{0, 0, 0, 0,       0, 0, 0, 0,                   0, 0, 0, 32'h8000_0000, 0, 0,           1, 32'h5A, 0};
    // CPU write then read-back
    tbl[7] = '{1, 1, 32'h20, 32'h77, 0, 0, 0, 0,               1, 0, 1, 32'h0,        0, 0,            0, 0,     0};
    tbl[8] = '{1, 0, 32'h20, 0,  0, 0, 0, 0,                   1, 0, 0, 32'h20,       0, 0,            0, 0,     0};
    tbl[9] = '{0, 0, 0, 0,       0, 0, 0, 0,                   0, 0, 0, 32'h20,       1, 32'h77,       0, 0,     0};

    for (int i = 0; i < 256; i++) ref_bram[i] = init_word(i);
    for (int i = 0; i < 4; i++) ref_mmio[i] = init_mmio(i);
    model_reset();

    rst = 1'b1; init_mem = 1'b1;
    set_cpu(0, 0, 0, 0);
    set_ldr(0, 0, 0, 0);
    @(posedge clk); #1;
    init_mem = 1'b0;

    // reset held, then idle
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      model_check();
      chk("idle_fetch", bus.mem_fetch_addr, 0);
      chk("idle_we", bus.mem_we, 0);
      finish_cycle();
    end

    // directed table
    for (int i = 0; i < 10; i++) begin
      set_cpu(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd);
      set_ldr(tbl[i].lr, tbl[i].lw, tbl[i].la, tbl[i].ld);
      @(negedge clk);
      model_check();
      chk($sformatf("v%0d_cpu_gnt", i), bus.cpu_gnt, tbl[i].gc);
      chk($sformatf("v%0d_ldr_gnt", i), bus.ldr_gnt, tbl[i].gl);
      chk($sformatf("v%0d_mem_we", i), bus.mem_we, tbl[i].we);
      chk($sformatf("v%0d_fetch", i), bus.mem_fetch_addr, tbl[i].fa);
      chk($sformatf("v%0d_cpu_rv", i), bus.cpu_rvalid, tbl[i].crv);
      chk($sformatf("v%0d_cpu_rd", i), bus.cpu_rdata, tbl[i].crd);
      chk($sformatf("v%0d_ldr_rv", i), bus.ldr_rvalid, tbl[i].lrv);
      chk($sformatf("v%0d_ldr_rd", i), bus.ldr_rdata, tbl[i].lrd);
      chk($sformatf("v%0d_ldr_err", i), bus.ldr_err, tbl[i].err);
      finish_cycle();
    end
    chk("mmio_unchanged", mmio[2], 32'h0000_0099);

    // both requesting continuously: CPU x4 then loader, repeating
    set_ldr(1, 0, 32'h0000_0040, 0);
    for (int k = 0; k < 10; k++) begin
      set_cpu(1, 0, 32'(k * 4), 0);
      @(negedge clk);
      model_check();
      chk($sformatf("starve%0d_ldr", k), bus.ldr_gnt, (k % 5) == 4);
      chk($sformatf("starve%0d_cpu", k), bus.cpu_gnt, (k % 5) != 4);
      finish_cycle();
    end
    set_cpu(0, 0, 0, 0);
    set_ldr(0, 0, 0, 0);
    step();

    // reset right after a granted CPU read: response is killed, counter cleared
    set_cpu(1, 0, 32'h10, 0);
    set_ldr(1, 0, 32'h0000_0044, 0);
    repeat (2) step();
    rst = 1'b1;
    @(negedge clk);
    model_check();
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    finish_cycle();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      model_check();
      chk($sformatf("post_rst%0d_ldr", k), bus.ldr_gnt, k == 4);
      finish_cycle();
    end
    set_cpu(0, 0, 0, 0);
    set_ldr(0, 0, 0, 0);
    step();

    // random traffic; the loader keeps its request stable until granted
    ldr_hold = 0;
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      rst = ($urandom_range(0, 59) == 0);
      a = ($urandom_range(0, 3) == 0) ? (32'h8000_0000 | 32'($urandom_range(0, 3) * 4))
                                      : 32'($urandom_range(0, 31) * 4);
      set_cpu($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, a, $urandom);
      if (!ldr_hold) begin
        a = ($urandom_range(0, 2) == 0) ? (32'h8000_0000 | 32'($urandom_range(0, 3) * 4))
                                        : 32'($urandom_range(0, 31) * 4);
        set_ldr($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, a, $urandom);
      end
      @(negedge clk);
      model_check();
      ldr_hold = bus.ldr_req && !e_lg;
      finish_cycle();
    end
    rst = 1'b0;
    set_cpu(0, 0, 0, 0);
    set_ldr(0, 0, 0, 0);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
